// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Main control FSM of the multicycle MIPS core. Decodes the opcode
//            held in the instruction register, sequences fetch, decode,
//            execute, memory and writeback, and drives every datapath enable,
//            mux select and the ALUOp code for the ALU control decoder.
// Ports    : clk            - system clock, rising edge
//            reset          - asynchronous, active-low reset
//            OP[5:0]        - opcode field from the IR
//            PCWrite        - unconditional PC load
//            PCWriteCondEQ  - PC load when ALU Zero=1 (BEQ)
//            PCWriteCondNE  - PC load when ALU Zero=0 (BNE)
//            IorD           - memory address select (0=PC, 1=ALUOut)
//            MemRead/MemWrite - memory strobes
//            IRWrite        - instruction register load
//            MemtoReg       - regfile write data (0=ALUOut, 1=MDR)
//            RegDst         - write register (0=rt, 1=rd)
//            RegWrite       - regfile write enable
//            ALUSrcA        - 0=PC, 1=rs
//            ALUSrcB[1:0]   - 00=rt, 01=4, 10=ext imm, 11=ext imm<<2
//            ExtZero        - zero-extend immediate (ORI)
//            PCSource[1:0]  - 00=ALU result, 01=ALUOut, 10=jump target
//            ALUOp[1:0]     - 00=add, 01=or, 10=sub, 11=R-type
//            InstrDone      - final cycle of each instruction
//            IllegalOp      - DECODE with an unsupported opcode (Mealy)
//            State          - current state code, for debug
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    output logic               PCWrite,
    output logic               PCWriteCondEQ,
    output logic               PCWriteCondNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtZero,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic               InstrDone,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEXE = 4'd10,
        S_ORIEXE  = 4'd11,
        S_IDLE    = 4'd12,
        S_IWB     = 4'd13
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // All Moore outputs bundled so they can be decoded and registered together.
    typedef struct packed {
        logic       pc_write;
        logic       pc_cond_eq;
        logic       pc_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_illegal;

    // Opcode not in the supported set.
    always_comb begin
        w_illegal = 1'b1;
        case (OP)
            c_OP_RTYPE, c_OP_J, c_OP_BEQ, c_OP_BNE,
            c_OP_ADDI, c_OP_ORI, c_OP_LW, c_OP_SW: w_illegal = 1'b0;
            default:                               w_illegal = 1'b1;
        endcase
    end

    // Next-state logic. OP is only consulted in DECODE and MEMADR.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_IDLE:    w_next = S_FETCH;
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (OP)
                    c_OP_RTYPE:         w_next = S_RTEXE;
                    c_OP_LW, c_OP_SW:   w_next = S_MEMADR;
                    c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
                    c_OP_J:             w_next = S_JUMP;
                    c_OP_ADDI:          w_next = S_ADDIEXE;
                    c_OP_ORI:           w_next = S_ORIEXE;
                    default:            w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (OP == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTEXE:   w_next = S_RTWB;
            S_ADDIEXE: w_next = S_IWB;
            S_ORIEXE:  w_next = S_IWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decode of the state being entered; registering it yields Moore
    // outputs that line up with State without a combinational path from it.
    // The branch condition selects use OP at the DECODE->BRANCH edge, so later
    // OP changes have no effect.
    always_comb begin
        w_ctrl = '0;
        case (w_next)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEXE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.iord       = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_RTEXE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = 2'b11;
            end
            S_RTWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_op     = 2'b10;
                w_ctrl.pc_source  = 2'b01;
                w_ctrl.pc_cond_eq = (OP == c_OP_BEQ);
                w_ctrl.pc_cond_ne = (OP == c_OP_BNE);
                w_ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = 2'b10;
                w_ctrl.instr_done = 1'b1;
            end
            S_ORIEXE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = 2'b10;
                w_ctrl.ext_zero  = 1'b1;
                w_ctrl.alu_op    = 2'b01;
            end
            S_IWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // State register and registered outputs; async reset clears every strobe
    // immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            PCWrite       <= 1'b0;
            PCWriteCondEQ <= 1'b0;
            PCWriteCondNE <= 1'b0;
            IorD          <= 1'b0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            IRWrite       <= 1'b0;
            MemtoReg      <= 1'b0;
            RegDst        <= 1'b0;
            RegWrite      <= 1'b0;
            ALUSrcA       <= 1'b0;
            ALUSrcB       <= 2'b00;
            ExtZero       <= 1'b0;
            PCSource      <= 2'b00;
            ALUOp         <= 2'b00;
            InstrDone     <= 1'b0;
        end else begin
            r_state       <= w_next;
            PCWrite       <= w_ctrl.pc_write;
            PCWriteCondEQ <= w_ctrl.pc_cond_eq;
            PCWriteCondNE <= w_ctrl.pc_cond_ne;
            IorD          <= w_ctrl.iord;
            MemRead       <= w_ctrl.mem_read;
            MemWrite      <= w_ctrl.mem_write;
            IRWrite       <= w_ctrl.ir_write;
            MemtoReg      <= w_ctrl.mem_to_reg;
            RegDst        <= w_ctrl.reg_dst;
            RegWrite      <= w_ctrl.reg_write;
            ALUSrcA       <= w_ctrl.alu_src_a;
            ALUSrcB       <= w_ctrl.alu_src_b;
            ExtZero       <= w_ctrl.ext_zero;
            PCSource      <= w_ctrl.pc_source;
            ALUOp         <= w_ctrl.alu_op;
            InstrDone     <= w_ctrl.instr_done;
        end
    end

    // Only combinational output: flags a bad opcode while it is being decoded.
    assign IllegalOp = (r_state == S_DECODE) && w_illegal;
    assign State     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control. A table of per-cycle
//            {OP, expected State, expected outputs} records walks every
//            instruction class; hand-written sequences cover reset entry/exit
//            and an asynchronous reset in the middle of a store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] OP;
    logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtZero;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic       InstrDone, IllegalOp;
    logic [3:0] State;

    int n_vec;
    int n_err;

    multicycle_control #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .OP            (OP),
        .PCWrite       (PCWrite),
        .PCWriteCondEQ (PCWriteCondEQ),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ExtZero       (ExtZero),
        .PCSource      (PCSource),
        .ALUOp         (ALUOp),
        .InstrDone     (InstrDone),
        .IllegalOp     (IllegalOp),
        .State         (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word layout (MSB first):
    // PCWrite | EQ NE IorD | MemRead MemWrite IRWrite | MemtoReg RegDst RegWrite |
    // ALUSrcA | ALUSrcB[1:0] | ExtZero | PCSource[1:0] | ALUOp[1:0] | InstrDone | IllegalOp
    localparam logic [20:0] c_ZERO   = 21'b0;
    localparam logic [20:0] c_FETCH  = 21'b1_000_1_0_1_000_0_01_0_00_00_0_0;
    localparam logic [20:0] c_DEC    = 21'b0_000_0_0_0_000_0_11_0_00_00_0_0;
    localparam logic [20:0] c_DECILL = 21'b0_000_0_0_0_000_0_11_0_00_00_0_1;
    localparam logic [20:0] c_MEMADR = 21'b0_000_0_0_0_000_1_10_0_00_00_0_0;
    localparam logic [20:0] c_MEMRD  = 21'b0_001_1_0_0_000_0_00_0_00_00_0_0;
    localparam logic [20:0] c_MEMWB  = 21'b0_000_0_0_0_101_0_00_0_00_00_1_0;
    localparam logic [20:0] c_MEMWR  = 21'b0_001_0_1_0_000_0_00_0_00_00_1_0;
    localparam logic [20:0] c_RTEXE  = 21'b0_000_0_0_0_000_1_00_0_00_11_0_0;
    localparam logic [20:0] c_RTWB   = 21'b0_000_0_0_0_011_0_00_0_00_00_1_0;
    localparam logic [20:0] c_BEQ    = 21'b0_100_0_0_0_000_1_00_0_01_10_1_0;
    localparam logic [20:0] c_BNE    = 21'b0_010_0_0_0_000_1_00_0_01_10_1_0;
    localparam logic [20:0] c_JUMP   = 21'b1_000_0_0_0_000_0_00_0_10_00_1_0;
    localparam logic [20:0] c_ADDI   = 21'b0_000_0_0_0_000_1_10_0_00_00_0_0;
    localparam logic [20:0] c_ORI    = 21'b0_000_0_0_0_000_1_10_1_00_01_0_0;
    localparam logic [20:0] c_IWB    = 21'b0_000_0_0_0_001_0_00_0_00_00_1_0;

    // op: OP driven before the clock edge that enters exp_state; it stays
    // applied while that state is checked.
    typedef struct {
        logic [5:0]  op;
        logic [3:0]  exp_state;
        logic [20:0] exp_out;
    } vec_t;

    localparam int N_VEC = 35;
    vec_t vecs [N_VEC];

    function automatic logic [20:0] outs();
        return {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
                IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtZero,
                PCSource, ALUOp, InstrDone, IllegalOp};
    endfunction

    task automatic check(input string name, input logic [3:0] exp_st,
                         input logic [20:0] exp_o);
        n_vec++;
        if (State !== exp_st || outs() !== exp_o) begin
            n_err++;
            $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
                     name, State, outs(), exp_st, exp_o);
        end
    endtask

    initial begin
        // LW, with OP scrambled in states that must ignore it
        vecs[0]  = '{6'h11, 4'd0,  c_FETCH};
        vecs[1]  = '{6'h23, 4'd1,  c_DEC};
        vecs[2]  = '{6'h23, 4'd2,  c_MEMADR};
        vecs[3]  = '{6'h23, 4'd3,  c_MEMRD};
        vecs[4]  = '{6'h3F, 4'd4,  c_MEMWB};
        // R-type
        vecs[5]  = '{6'h2B, 4'd0,  c_FETCH};
        vecs[6]  = '{6'h00, 4'd1,  c_DEC};
        vecs[7]  = '{6'h00, 4'd6,  c_RTEXE};
        vecs[8]  = '{6'h23, 4'd7,  c_RTWB};
        // ORI
        vecs[9]  = '{6'h00, 4'd0,  c_FETCH};
        vecs[10] = '{6'h0D, 4'd1,  c_DEC};
        vecs[11] = '{6'h0D, 4'd11, c_ORI};
        vecs[12] = '{6'h04, 4'd13, c_IWB};
        // BEQ
        vecs[13] = '{6'h04, 4'd0,  c_FETCH};
        vecs[14] = '{6'h04, 4'd1,  c_DEC};
        vecs[15] = '{6'h04, 4'd8,  c_BEQ};
        // BNE
        vecs[16] = '{6'h05, 4'd0,  c_FETCH};
        vecs[17] = '{6'h05, 4'd1,  c_DEC};
        vecs[18] = '{6'h05, 4'd8,  c_BNE};
        // J
        vecs[19] = '{6'h02, 4'd0,  c_FETCH};
        vecs[20] = '{6'h02, 4'd1,  c_DEC};
        vecs[21] = '{6'h02, 4'd9,  c_JUMP};
        // ADDI
        vecs[22] = '{6'h08, 4'd0,  c_FETCH};
        vecs[23] = '{6'h08, 4'd1,  c_DEC};
        vecs[24] = '{6'h08, 4'd10, c_ADDI};
        vecs[25] = '{6'h08, 4'd13, c_IWB};
        // Illegal opcode: two cycles, no writes, no InstrDone
        vecs[26] = '{6'h3F, 4'd0,  c_FETCH};
        vecs[27] = '{6'h3F, 4'd1,  c_DECILL};
        vecs[28] = '{6'h3F, 4'd0,  c_FETCH};
        // SW
        vecs[29] = '{6'h2B, 4'd1,  c_DEC};
        vecs[30] = '{6'h2B, 4'd2,  c_MEMADR};
        vecs[31] = '{6'h2B, 4'd5,  c_MEMWR};
        vecs[32] = '{6'h00, 4'd0,  c_FETCH};
        vecs[33] = '{6'h2B, 4'd1,  c_DEC};
        vecs[34] = '{6'h2B, 4'd2,  c_MEMADR};

        n_vec = 0;
        n_err = 0;
        OP    = 6'h00;
        reset = 1'b0;

        // Reset held for three cycles: IDLE with everything low.
        repeat (3) begin
            @(posedge clk);
            #1 check("reset_hold", 4'd12, c_ZERO);
        end

        // Release between edges; IDLE holds until the next edge.
        reset = 1'b1;
        #1 check("idle_after_release", 4'd12, c_ZERO);

        for (int i = 0; i < N_VEC; i++) begin
            OP = vecs[i].op;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_out);
        end

        // Sitting in MEMADR with OP=SW; step into MEMWR, then pull reset
        // between edges and look at the strobes before any clock edge.
        @(posedge clk);
        #1 check("sw_memwr", 4'd5, c_MEMWR);
        #2 reset = 1'b0;
        #1 check("async_reset_memwr", 4'd12, c_ZERO);
        @(posedge clk);
        #1 check("reset_low_edge", 4'd12, c_ZERO);
        reset = 1'b1;
        #1 check("idle_after_rerelease", 4'd12, c_ZERO);
        OP = 6'h23;
        @(posedge clk);
        #1 check("fetch_after_reset", 4'd0, c_FETCH);
        @(posedge clk);
        #1 check("decode_after_reset", 4'd1, c_DEC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
